// File: rtl/mem_stage.sv
// RV32I memory-access stage with MEM/WB pipeline register: issues loads/stores on a
// req/gnt/rvalid bus, aligns load data, stalls upstream while an access is in flight.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc4,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_to_reg,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_mem_rdata,
  output logic [4:0]  out_rd,
  output logic [1:0]  out_mem_to_reg,
  output logic        out_reg_write,
  output logic        misaligned,
  output logic        bus_err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_pc4, r_addr, r_wdata;
  logic [4:0]    r_rd;
  logic [2:0]    r_f3;
  logic          r_we, r_rw;
  logic [1:0]    r_sel;

  logic w_is_mem, w_illegal, w_misal, w_bad;
  logic w_req, w_last, w_fin_store, w_fin_load, w_to, w_fin;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Decode of the incoming instruction, only meaningful for memory ops
  assign w_is_mem  = mem_read | mem_write;
  assign w_illegal = (mem_read & mem_write)
                   | (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
                   | (mem_write & (funct3[2] | (funct3[1:0] == 2'b11)));
  assign w_misal   = ((funct3[1:0] == 2'b01) & alu_result[0])
                   | ((funct3[1:0] == 2'b10) & (|alu_result[1:0]));
  assign w_bad     = w_is_mem & (w_illegal | w_misal);

  assign in_ready    = (r_state == S_IDLE);
  assign w_req       = (r_state == S_REQ);
  assign w_last      = (r_cnt == CW'(TIMEOUT - 1));
  assign w_fin_store = w_req & dmem_gnt & r_we;
  assign w_fin_load  = (r_state == S_WAIT) & dmem_rvalid;
  assign w_to        = w_last & ((w_req & ~dmem_gnt) | ((r_state == S_WAIT) & ~dmem_rvalid));
  assign w_fin       = w_fin_store | w_fin_load | w_to;

  assign dmem_req  = w_req;
  assign dmem_we   = w_req & r_we;
  assign dmem_addr = w_req ? {r_addr[31:2], 2'b00} : 32'd0;

  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = 32'd0;
    if (w_req) begin
      case (r_f3[1:0])
        2'b00:   dmem_wdata = {4{r_wdata[7:0]}};
        2'b01:   dmem_wdata = {2{r_wdata[15:0]}};
        default: dmem_wdata = r_wdata;
      endcase
      if (!r_we)                   dmem_be = 4'b1111;
      else if (r_f3[1:0] == 2'b00) dmem_be = 4'b0001 << r_addr[1:0];
      else if (r_f3[1:0] == 2'b01) dmem_be = 4'b0011 << {r_addr[1], 1'b0};
      else                         dmem_be = 4'b1111;
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_pc4          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rd           <= '0;
      r_f3           <= '0;
      r_we           <= 1'b0;
      r_rw           <= 1'b0;
      r_sel          <= '0;
      out_valid      <= 1'b0;
      out_pc4        <= '0;
      out_alu_result <= '0;
      out_mem_rdata  <= '0;
      out_rd         <= '0;
      out_mem_to_reg <= '0;
      out_reg_write  <= 1'b0;
      misaligned     <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_pc4   <= pc4;
          r_addr  <= alu_result;
          r_wdata <= rs2_data;
          r_rd    <= rd;
          r_f3    <= funct3;
          r_we    <= mem_write;
          r_rw    <= reg_write;
          r_sel   <= mem_to_reg;
          if (!w_is_mem || w_bad) begin
            out_valid      <= 1'b1;
            out_pc4        <= pc4;
            out_alu_result <= alu_result;
            out_rd         <= rd;
            out_mem_to_reg <= mem_to_reg;
            out_reg_write  <= reg_write & ~w_bad;
            misaligned     <= w_bad;
          end else begin
            r_state <= S_REQ;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (dmem_gnt && !r_we) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: r_cnt <= r_cnt + 1'b1;
        default: r_state <= S_IDLE;
      endcase
      // Completion of a bus access (store grant, load data, or timeout abort)
      if (w_fin) begin
        r_state        <= S_IDLE;
        out_valid      <= 1'b1;
        out_pc4        <= r_pc4;
        out_alu_result <= r_addr;
        out_rd         <= r_rd;
        out_mem_to_reg <= r_sel;
        out_reg_write  <= r_rw & ~w_to;
        bus_err        <= w_to;
        if (w_fin_load)  out_mem_rdata <= w_load_data;
        else if (w_to)   out_mem_rdata <= 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized ops, a bus responder driven by a per-access
// plan, and a monitor comparing each out_valid against an arithmetic reference model.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] pc4, alu_result, rs2_data;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        mem_read, mem_write, reg_write;
  logic [1:0]  mem_to_reg;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        out_valid, out_reg_write, misaligned, bus_err;
  logic [31:0] out_pc4, out_alu_result, out_mem_rdata;
  logic [4:0]  out_rd;
  logic [1:0]  out_mem_to_reg;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc4(pc4), .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd),
    .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_alu_result(out_alu_result),
    .out_mem_rdata(out_mem_rdata), .out_rd(out_rd), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .misaligned(misaligned), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4, alu, rdata;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        rw, mis, berr;
  } exp_t;

  typedef struct {
    int          gd, rv;
    logic [31:0] rdata, addr, wdata;
    logic        we;
    logic [3:0]  be;
  } plan_t;

  exp_t        exp_q[$];
  plan_t       plan_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_last = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: derives the bus plan and WB result from the ISA rules directly
  task automatic issue(input logic [31:0] pc4_v, input logic [31:0] alu_v,
                       input logic [31:0] rs2_v, input logic [4:0] rd_v,
                       input logic [2:0] f3, input logic mr, input logic mw,
                       input logic [1:0] sel, input logic rw,
                       input int gd, input int rvd, input logic [31:0] rdata_v);
    int    guard;
    logic  memop, ill, mis, bad, to;
    int    sz;
    logic [31:0] b, h, val;
    exp_t  e;
    plan_t p;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    pc4 = pc4_v; alu_result = alu_v; rs2_data = rs2_v; rd = rd_v; funct3 = f3;
    mem_read = mr; mem_write = mw; mem_to_reg = sel; reg_write = rw; in_valid = 1'b1;

    memop = mr | mw;
    sz    = int'(f3) % 4;
    ill   = (mr && mw) || (mr && (f3 == 3 || f3 == 6 || f3 == 7)) || (mw && f3 >= 3);
    mis   = (sz == 1 && (alu_v % 2) != 0) || (sz == 2 && (alu_v % 4) != 0);
    bad   = memop && (ill || mis);
    e.pc4 = pc4_v; e.alu = alu_v; e.rd = rd_v; e.sel = sel;
    if (!memop || bad) begin
      e.rw = rw && !bad; e.mis = bad; e.berr = 1'b0; e.rdata = m_last;
    end else begin
      to = (gd >= TO) || (mr && rvd >= TO);
      p.gd = gd; p.rv = rvd; p.rdata = rdata_v; p.addr = alu_v - (alu_v % 4); p.we = mw;
      if (mr)           begin p.be = 4'hF; p.wdata = 32'd0; end
      else if (sz == 0) begin p.be = 4'(1 << (alu_v % 4)); p.wdata = (rs2_v % 256) * 32'h01010101; end
      else if (sz == 1) begin p.be = 4'(3 << (alu_v % 4)); p.wdata = (rs2_v % 65536) * 32'h00010001; end
      else              begin p.be = 4'hF; p.wdata = rs2_v; end
      plan_q.push_back(p);
      b = (rdata_v >> (8 * (alu_v % 4))) % 256;
      h = (rdata_v >> (16 * ((alu_v / 2) % 2))) % 65536;
      case (f3)
        3'd0:    val = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd4:    val = b;
        3'd1:    val = (h >= 32768) ? h + 32'hFFFF0000 : h;
        3'd5:    val = h;
        default: val = rdata_v;
      endcase
      e.rw = rw && !to; e.mis = 1'b0; e.berr = to;
      e.rdata = to ? 32'd0 : (mr ? val : m_last);
    end
    m_last = e.rdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Bus responder: follows the plan of each access, jitters rvalid during REQ
  initial begin
    plan_t p;
    int    k;
    logic  done;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (dmem_req && !rst) begin
        if (plan_q.size() == 0) begin
          chk("unplanned_req", 32'(dmem_req), 32'd0);
        end else begin
          p = plan_q.pop_front();
          chk("dmem_addr", dmem_addr, p.addr);
          chk("dmem_we", 32'(dmem_we), 32'(p.we));
          chk("dmem_be", 32'(dmem_be), 32'(p.be));
          if (p.we) chk("dmem_wdata", dmem_wdata, p.wdata);
          k = 0; done = 1'b0;
          while (dmem_req && !done && k <= TO + 2) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            dmem_gnt    = (k == p.gd);
            dmem_rvalid = (k != p.gd) ? 1'($urandom_range(0, 1)) : 1'b0;
            dmem_rdata  = $urandom;
            @(posedge clk); #1;
            done = dmem_gnt;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            k++;
          end
          chk("req_cycles", 32'(k), 32'((p.gd < TO) ? p.gd + 1 : TO));
          if (done && !p.we) begin
            for (int j = 0; j < TO; j++) begin
              dmem_rvalid = (j == p.rv);
              dmem_rdata  = (j == p.rv) ? p.rdata : $urandom;
              @(posedge clk); #1;
              dmem_rvalid = 1'b0;
              if (j == p.rv) break;
            end
          end
        end
      end
    end
  end

  // Monitor: pops one expected result per out_valid pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc4", out_pc4, e.pc4);
            chk("out_alu_result", out_alu_result, e.alu);
            chk("out_mem_rdata", out_mem_rdata, e.rdata);
            chk("out_rd", 32'(out_rd), 32'(e.rd));
            chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(e.sel));
            chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
            chk("misaligned", 32'(misaligned), 32'(e.mis));
            chk("bus_err", 32'(bus_err), 32'(e.berr));
            $display("txn done pc4=%h alu=%h rdata=%h rd=%0d mis=%b berr=%b",
                     out_pc4, out_alu_result, out_mem_rdata, out_rd, misaligned, bus_err);
          end
        end else begin
          chk("flags_idle", 32'({misaligned, bus_err}), 32'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] lf3 [5];
    logic [2:0] sf3 [3];
    int         kind, guard;
    logic       mr, mw;
    logic [2:0] f3;
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    sf3 = '{3'd0, 3'd1, 3'd2};
    rst = 1'b1; in_valid = 1'b0; pc4 = 0; alu_result = 0; rs2_data = 0; rd = 0;
    funct3 = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_out_pc4", out_pc4, 32'd0);
    chk("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed: ALU op then four back-to-back
    issue(32'h104, 32'h55, 32'h0, 5'd3, 3'd0, 1'b0, 1'b0, 2'd2, 1'b1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      issue(32'h200 + 4 * i, 32'h1000 + i, 32'h0, 5'(i + 1), 3'd0, 1'b0, 1'b0, 2'd2, 1'b1, 0, 0, 32'h0);
    // SB with grant after 2 cycles; loads with alignment; misaligned LW; timeout
    issue(32'h304, 32'h1003, 32'hAB, 5'd0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2, 0, 32'h0);
    issue(32'h308, 32'h2001, 32'h0, 5'd5, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1, 1, 32'h000080FF);
    issue(32'h30C, 32'h2002, 32'h0, 5'd6, 3'd5, 1'b1, 1'b0, 2'd1, 1'b1, 0, 2, 32'hBEEF1234);
    issue(32'h310, 32'h2000, 32'h0, 5'd7, 3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 0, 0, 32'hDEADBEEF);
    issue(32'h314, 32'h3002, 32'h0, 5'd8, 3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 0, 0, 32'h0);
    issue(32'h318, 32'h4000, 32'h0, 5'd9, 3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 0, 50, 32'h12345678);
    issue(32'h31C, 32'h4004, 32'h0, 5'd10, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0, TO, 0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      mr = (kind >= 3 && kind <= 5) || kind == 9;
      mw = kind >= 6;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (mr && !mw) f3 = lf3[$urandom_range(0, 4)];
        if (mw && !mr) f3 = sf3[$urandom_range(0, 2)];
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      issue($urandom, $urandom, $urandom, 5'($urandom), f3, mr, mw, 2'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
    end

    guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    // Reset in WAIT: access aborted, late rvalid after reset must be ignored
    issue(32'h500, 32'h6000, 32'h0, 5'd11, 3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 0, 3, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("wait_in_ready", 32'(in_ready), 32'd0);
    chk("wait_dmem_req", 32'(dmem_req), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_dmem_req", 32'(dmem_req), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    void'(exp_q.pop_back());
    m_last = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    issue(32'h600, 32'h77, 32'h0, 5'd12, 3'd0, 1'b0, 1'b0, 2'd2, 1'b1, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    chk("final_plans", 32'(plan_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
